// File: rtl/fifo_drain_scheduler_pkg.sv
// Shared types and constants for the FIFO drain scheduler.
package fifo_drain_scheduler_pkg;

  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_WIDTH   = 64;
  localparam int BURST_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Index width for n channels; never returns less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_drain_scheduler_if.sv
// Source-FIFO read side and pipe-FIFO write side of the scheduler.
interface fifo_drain_scheduler_if
  import fifo_drain_scheduler_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int WIDTH   = DEF_WIDTH
);

  logic [NUM_SRC*WIDTH-1:0] src_dout;
  logic [NUM_SRC-1:0]       src_empty;
  logic [NUM_SRC-1:0]       src_rd_en;
  logic                     dst_full;
  logic [WIDTH-1:0]         dst_din;
  logic                     dst_wr_en;

  // Scheduler side: pops sources, writes the pipe FIFO.
  modport master (
    input  src_dout, src_empty, dst_full,
    output src_rd_en, dst_din, dst_wr_en
  );

  // FIFO side: presents words and flags, consumes strobes.
  modport slave (
    output src_dout, src_empty, dst_full,
    input  src_rd_en, dst_din, dst_wr_en
  );

endinterface

// File: rtl/fifo_drain_scheduler_rr_priority_picker.sv
// Combinational arbiter: channel 0 wins unless its burst budget is spent
// while another channel waits; channels 1..NUM_SRC-1 rotate from rr_ptr.
module rr_priority_picker
  import fifo_drain_scheduler_pkg::*;
#(
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int MAX_BURST = 8,
  parameter int IDX_W     = clog2(NUM_SRC),
  parameter int CNT_W     = BURST_W
) (
  input  logic [NUM_SRC-1:0] elig,
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic [CNT_W-1:0]   burst_cnt,
  output logic [IDX_W-1:0]   winner,
  output logic               win_valid,
  output logic               win_is_prio
);

  logic             others;
  logic             rr_found;
  logic [IDX_W-1:0] rr_win;
  logic [IDX_W:0]   pos;

  assign others = |elig[NUM_SRC-1:1];

  // Cyclic search over 1..NUM_SRC-1 starting at rr_ptr (channel 0 is skipped).
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    pos      = '0;
    for (int k = 0; k < NUM_SRC - 1; k++) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NUM_SRC)) pos = pos - (IDX_W+1)'(NUM_SRC - 1);
      if (!rr_found && elig[pos[IDX_W-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = pos[IDX_W-1:0];
      end
    end
  end

  // Priority channel first, subject to the starvation guard.
  always_comb begin
    winner      = '0;
    win_valid   = 1'b0;
    win_is_prio = 1'b0;
    if (elig[0] && ((burst_cnt < CNT_W'(MAX_BURST)) || !others)) begin
      win_valid   = 1'b1;
      win_is_prio = 1'b1;
    end else if (rr_found) begin
      winner    = rr_win;
      win_valid = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_drain_scheduler.sv
// Drains NUM_SRC fall-through source FIFOs into one pipe FIFO, one word
// every three cycles: IDLE (grant) -> XFER (write+pop land) -> SETTLE.
module fifo_drain_scheduler
  import fifo_drain_scheduler_pkg::*;
#(
  parameter int  NUM_SRC   = DEF_NUM_SRC,
  parameter int  WIDTH     = DEF_WIDTH,
  parameter int  MAX_BURST = 8,
  localparam int IDX_W     = clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_drain_scheduler_if.master bus,
  input  logic [NUM_SRC-1:0]    chan_enable,
  output logic [IDX_W-1:0]      grant_id,
  output logic                  busy,
  output logic [31:0]           xfer_count
);

  state_t               state, next_state;
  logic                 grant;
  logic [NUM_SRC-1:0]   elig;
  logic [IDX_W-1:0]     winner;
  logic                 win_valid, win_is_prio;
  logic [IDX_W-1:0]     rr_ptr;
  logic [BURST_W-1:0]   burst_cnt;
  logic [WIDTH-1:0]     words [NUM_SRC];

  assign elig = ~bus.src_empty & chan_enable;
  assign busy = (state != IDLE);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign words[i] = bus.src_dout[i*WIDTH +: WIDTH];
  end

  rr_priority_picker #(
    .NUM_SRC   (NUM_SRC),
    .MAX_BURST (MAX_BURST),
    .IDX_W     (IDX_W),
    .CNT_W     (BURST_W)
  ) u_picker (
    .elig        (elig),
    .rr_ptr      (rr_ptr),
    .burst_cnt   (burst_cnt),
    .winner      (winner),
    .win_valid   (win_valid),
    .win_is_prio (win_is_prio)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next state; a grant is taken only from IDLE with room downstream.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.dst_full && win_valid) begin
          grant      = 1'b1;
          next_state = XFER;
        end
      end
      XFER:    next_state = SETTLE;
      SETTLE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Register the granted word and raise write/pop strobes for exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dst_din   <= '0;
      bus.dst_wr_en <= 1'b0;
      bus.src_rd_en <= '0;
      grant_id      <= '0;
    end else if (grant) begin
      bus.dst_din   <= words[winner];
      bus.dst_wr_en <= 1'b1;
      bus.src_rd_en <= NUM_SRC'(1) << winner;
      grant_id      <= winner;
    end else begin
      bus.dst_wr_en <= 1'b0;
      bus.src_rd_en <= '0;
    end
  end

  // Fairness state: burst length of channel 0 and the round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt <= '0;
      rr_ptr    <= IDX_W'(1);
    end else if (grant) begin
      if (win_is_prio) begin
        if (burst_cnt != {BURST_W{1'b1}}) burst_cnt <= burst_cnt + 1'b1;
      end else begin
        burst_cnt <= '0;
        if (winner == IDX_W'(NUM_SRC - 1)) rr_ptr <= IDX_W'(1);
        else                               rr_ptr <= winner + 1'b1;
      end
    end
  end

  // Count completed transfers as each XFER cycle retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               xfer_count <= '0;
    else if (state == XFER) xfer_count <= xfer_count + 32'd1;
  end

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// Directed bench for fifo_drain_scheduler: two instances (MAX_BURST 8 and 2)
// fed by small fall-through FIFO models.
module tb_fifo_drain_scheduler;
  import fifo_drain_scheduler_pkg::*;

  localparam int NS = 4;
  localparam int W  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_drain_scheduler_if #(.NUM_SRC(NS), .WIDTH(W)) bus_a ();
  fifo_drain_scheduler_if #(.NUM_SRC(NS), .WIDTH(W)) bus_b ();

  logic [NS-1:0] en_a, en_b;
  logic [1:0]    gid_a, gid_b;
  logic          busy_a, busy_b;
  logic [31:0]   cnt_a, cnt_b;

  fifo_drain_scheduler #(.NUM_SRC(NS), .WIDTH(W), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst), .bus(bus_a), .chan_enable(en_a),
    .grant_id(gid_a), .busy(busy_a), .xfer_count(cnt_a)
  );

  fifo_drain_scheduler #(.NUM_SRC(NS), .WIDTH(W), .MAX_BURST(2)) dut_sb (
    .clk(clk), .rst(rst), .bus(bus_b), .chan_enable(en_b),
    .grant_id(gid_b), .busy(busy_b), .xfer_count(cnt_b)
  );

  // Source FIFO models: circular buffers, tail written by stimulus only.
  logic [W-1:0] mem  [2][NS][16];
  int           head [2][NS];
  int           tail [2][NS];
  int           pk   [2][NS];
  int           exp_k[2][NS];

  int passed = 0;
  int total  = 0;

  // Pops happen on the edge where the scheduler's read strobe is seen.
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (bus_a.src_rd_en[i] === 1'b1 && head[0][i] != tail[0][i]) head[0][i] <= head[0][i] + 1;
      if (bus_b.src_rd_en[i] === 1'b1 && head[1][i] != tail[1][i]) head[1][i] <= head[1][i] + 1;
    end
  end

  // Fall-through outputs refreshed mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      bus_a.src_empty[i]       <= (head[0][i] == tail[0][i]);
      bus_a.src_dout[i*W +: W] <= mem[0][i][head[0][i][3:0]];
      bus_b.src_empty[i]       <= (head[1][i] == tail[1][i]);
      bus_b.src_dout[i*W +: W] <= mem[1][i][head[1][i][3:0]];
    end
  end

  function automatic logic [63:0] word(input int ch, input int k);
    return 64'hC0DE_0000_0000_0000 | (64'(ch) << 8) | 64'(k);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input int d, input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      mem[d][ch][tail[d][ch][3:0]] = word(ch, pk[d][ch]);
      pk[d][ch]++;
      tail[d][ch]++;
    end
  endtask

  task automatic flush();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NS; i++) begin
        tail[d][i]  = head[d][i];
        pk[d][i]    = 0;
        exp_k[d][i] = 0;
      end
  endtask

  task automatic reset_assert();
    @(posedge clk); #1;
    rst = 1'b0;
    flush();
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Step cycles until a write strobe is seen or the budget runs out.
  task automatic next_wr(input int d, input int limit, output int waited, output logic seen);
    waited = 0;
    seen   = 1'b0;
    do begin
      @(posedge clk); #1;
      waited++;
      seen = (d == 0) ? (bus_a.dst_wr_en === 1'b1) : (bus_b.dst_wr_en === 1'b1);
    end while (!seen && waited < limit);
  endtask

  task automatic expect_grant(input int d, input int ch, input int gap, input string tag);
    int   waited;
    logic seen;
    next_wr(d, 20, waited, seen);
    check({tag, " wr_en"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, " grant_id"}, 64'((d == 0) ? gid_a : gid_b), 64'(ch));
      check({tag, " din"}, (d == 0) ? bus_a.dst_din : bus_b.dst_din, word(ch, exp_k[d][ch]));
      check({tag, " rd_en"}, 64'((d == 0) ? bus_a.src_rd_en : bus_b.src_rd_en), 64'(1) << ch);
      check({tag, " gap"}, 64'(waited), 64'(gap));
      exp_k[d][ch]++;
    end
  endtask

  initial begin
    int   waited;
    logic seen;
    logic bad;

    en_a = '1;
    en_b = '1;
    bus_a.dst_full = 1'b0;
    bus_b.dst_full = 1'b0;

    // Reset state
    reset_assert();
    #2;
    check("rst wr_en", 64'(bus_a.dst_wr_en), 64'd0);
    check("rst rd_en", 64'(bus_a.src_rd_en), 64'd0);
    check("rst din", bus_a.dst_din, 64'd0);
    check("rst grant_id", 64'(gid_a), 64'd0);
    check("rst count", cnt_a, 64'd0);
    check("rst busy", 64'(busy_a), 64'd0);
    reset_release();

    // Single word from channel 2
    mem[0][2][tail[0][2][3:0]] = 64'hDEAD_BEEF_0000_0002;
    tail[0][2]++;
    next_wr(0, 10, waited, seen);
    check("single wr_en", 64'(seen), 64'd1);
    check("single latency", 64'(waited), 64'd1);
    check("single din", bus_a.dst_din, 64'hDEAD_BEEF_0000_0002);
    check("single rd_en", 64'(bus_a.src_rd_en), 64'b0100);
    check("single grant_id", 64'(gid_a), 64'd2);
    check("single busy", 64'(busy_a), 64'd1);
    @(posedge clk); #1;
    check("single count", cnt_a, 64'd1);
    check("single wr_en drop", 64'(bus_a.dst_wr_en), 64'd0);
    check("single rd_en drop", 64'(bus_a.src_rd_en), 64'd0);

    // Priority: channel 0 drains before channel 1
    reset_assert();
    reset_release();
    push(0, 0, 3);
    push(0, 1, 3);
    expect_grant(0, 0, 1, "prio0");
    expect_grant(0, 0, 3, "prio1");
    expect_grant(0, 0, 3, "prio2");
    expect_grant(0, 1, 3, "prio3");
    expect_grant(0, 1, 3, "prio4");
    expect_grant(0, 1, 3, "prio5");

    // Starvation guard with MAX_BURST = 2
    reset_assert();
    reset_release();
    push(1, 0, 6);
    push(1, 1, 2);
    expect_grant(1, 0, 1, "starve0");
    expect_grant(1, 0, 3, "starve1");
    expect_grant(1, 1, 3, "starve2");
    expect_grant(1, 0, 3, "starve3");
    expect_grant(1, 0, 3, "starve4");
    expect_grant(1, 1, 3, "starve5");
    expect_grant(1, 0, 3, "starve6");
    expect_grant(1, 0, 3, "starve7");

    // Round-robin among 1..3
    reset_assert();
    reset_release();
    push(0, 1, 2);
    push(0, 2, 2);
    push(0, 3, 2);
    expect_grant(0, 1, 1, "rr0");
    expect_grant(0, 2, 3, "rr1");
    expect_grant(0, 3, 3, "rr2");
    expect_grant(0, 1, 3, "rr3");
    expect_grant(0, 2, 3, "rr4");
    expect_grant(0, 3, 3, "rr5");

    // Back-pressure holds off the grant
    reset_assert();
    reset_release();
    bus_a.dst_full = 1'b1;
    push(0, 1, 1);
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus_a.dst_wr_en !== 1'b0 || bus_a.src_rd_en !== '0 || busy_a !== 1'b0) bad = 1'b1;
    end
    check("full no strobes", 64'(bad), 64'd0);
    bus_a.dst_full = 1'b0;
    expect_grant(0, 1, 1, "full release");
    repeat (2) @(posedge clk);
    #1;
    check("full count", cnt_a, 64'd1);

    // Reset during XFER
    push(0, 1, 1);
    next_wr(0, 10, waited, seen);
    check("xfer wr_en", 64'(seen), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst wr_en", 64'(bus_a.dst_wr_en), 64'd0);
    check("midrst rd_en", 64'(bus_a.src_rd_en), 64'd0);
    check("midrst count", cnt_a, 64'd0);
    check("midrst busy", 64'(busy_a), 64'd0);
    flush();
    en_a = 4'b1101;
    reset_release();

    // Masked channel 1 is never granted
    push(0, 1, 1);
    push(0, 2, 1);
    expect_grant(0, 2, 1, "mask ch2");
    next_wr(0, 15, waited, seen);
    check("mask ch1 blocked", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/fifo_drain_scheduler.md
Name: fifo_drain_scheduler

Overview:
- Schedules transfers from NUM_SRC first-level fall-through FIFOs into the single shared second-level pipe FIFO.
- Channel 0 (pulse programmer) has priority, with a starvation guard. Channels 1..NUM_SRC-1 (ADC, counters, and so on) share the remaining slots round-robin.
- Sits between the source FIFOs and the pipe FIFO write port, all on the write clock domain. Drives every source read-enable and the destination write-enable.

Parameters:
- NUM_SRC, 4, number of source FIFOs (2..8); channel 0 is the priority channel.
- WIDTH, 64, data word width in bits.
- MAX_BURST, 8, maximum consecutive channel-0 grants while another eligible channel is waiting (1..255).

Ports:
- clk  input  1  write-side clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- src_dout  input  NUM_SRC*WIDTH  source FIFO outputs, channel i at bits [i*WIDTH +: WIDTH], fall-through.
- src_empty  input  NUM_SRC  source FIFO empty flags.
- src_rd_en  output  NUM_SRC  one-cycle pop strobes, at most one bit high.
- chan_enable  input  NUM_SRC  per-channel enable mask; a 0 bit makes the channel ineligible.
- dst_full  input  1  pipe FIFO full.
- dst_din  output  WIDTH  registered data to the pipe FIFO.
- dst_wr_en  output  1  one-cycle write strobe.
- grant_id  output  clog2(NUM_SRC)  channel of the most recent transfer.
- busy  output  1  high in any state other than IDLE.
- xfer_count  output  32  total words transferred, wrapping.

Behaviour:
- Reset (rst low, asynchronous assert, synchronous release):
  - state is IDLE.
  - src_rd_en, dst_wr_en, busy = 0; dst_din = 0; grant_id = 0; xfer_count = 0.
  - burst_cnt = 0; rr_ptr = 1.
- Eligibility: channel i is eligible when src_empty[i] = 0 and chan_enable[i] = 1.
- States: IDLE, XFER, SETTLE.
- IDLE:
  - If dst_full = 0 and any channel is eligible, select winner g.
  - Register dst_din <= src_dout[g], dst_wr_en <= 1, src_rd_en[g] <= 1, grant_id <= g. Go to XFER.
  - Otherwise remain in IDLE with all strobes 0.
- XFER:
  - dst_wr_en and src_rd_en drop to 0; xfer_count increments. Go to SETTLE.
  - The write and the pop therefore land in the same cycle.
- SETTLE:
  - One dead cycle so the source's empty flag and dout reflect the pop. Go to IDLE.
- Throughput: 3 cycles per word when a source stays non-empty. Latency from src_empty falling (IDLE, not full) to dst_wr_en high is 1 cycle.
- Winner selection:
  - If channel 0 is eligible and (burst_cnt < MAX_BURST, or no other channel is eligible): winner 0, burst_cnt increments (saturating).
  - Otherwise: winner is the first eligible channel in 1..NUM_SRC-1, searching cyclically from rr_ptr. Set rr_ptr to winner+1, wrapping NUM_SRC-1 to 1. Clear burst_cnt.
  - If channel 0 is not eligible at a grant decision, clear burst_cnt.
- Boundaries:
  - dst_full is sampled only in IDLE. A word already strobed is never withheld; the pipe FIFO guarantees one slot of margin at full assertion.
  - chan_enable changing mid-transfer does not affect the transfer in flight.
  - Simultaneous eligibility across all channels is resolved by the rules above, giving exactly one grant.
  - rst asserted mid-transfer clears all strobes immediately. Loss of the in-flight word is acceptable.
  - With NUM_SRC = 2, the round-robin pool is channel 1 only.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, XFER, SETTLE);
  - the clog2 helper function;
  - default WIDTH and NUM_SRC constants, shared with the multiplexer datapath.
- One sub-module, rr_priority_picker: combinational. Inputs: eligibility vector, rr_ptr, burst_cnt, MAX_BURST. Outputs: winner index, win_valid, win_is_prio.
- The state machine, registers and counters remain in the top module.

Test Plan:
- Single word: channel 2 holds 0xDEAD_BEEF_0000_0002, others empty. Required: dst_wr_en high 1 cycle after empty falls, dst_din = that value, src_rd_en[2] high in the same cycle, grant_id = 2, xfer_count = 1.
- Priority: channels 0 and 1 each hold 3 words. Required grant order 0,0,0,1,1,1; write strobes 3 cycles apart.
- Starvation guard: MAX_BURST = 2, channel 0 holds 6 words, channel 1 holds 2. Required grant order 0,0,1,0,0,1,0,0.
- Round-robin: channels 1, 2 and 3 each hold 2 words, channel 0 empty. Required grant order 1,2,3,1,2,3.
- Back-pressure: dst_full = 1 with channel 1 non-empty for 10 cycles. Required: no strobes. Release dst_full; required: dst_wr_en exactly 1 cycle later.
- Reset and mask: assert rst during XFER; required: all strobes 0 that cycle, xfer_count = 0. Then chan_enable = 4'b1101 with channels 1 and 2 loaded; required: only channel 2 is granted.
